mips_pipeline: RTL and testbench

- Top-level 5-stage pipelined MIPS-32 core (IF, ID, EX, MEM, WB) running a small integer subset.
- Self-contained: instruction memory, register file and data memory are internal.
- Only clock and reset are exposed. Programs are preloaded into instruction memory; verification observes state through fixed hierarchical names.

---
 rtl/mips_pipeline.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_mips_pipeline.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_pipeline.sv
// Five-stage MIPS-32 integer core (IF/ID/EX/MEM/WB) with internal instruction, register and data storage.
// EX-stage forwarding, one-cycle load-use stall, branch/jump resolved in EX with a two-slot flush.

module mips_imem #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        we,
    input  logic [9:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [9:0]  addr,
    output logic [31:0] rdata
);
    logic [31:0] imem [0:DEPTH-1];

    // Preload port only; the core never writes its own program.
    always_ff @(posedge clk) begin
        if (we) imem[waddr] <= wdata;
    end

    assign rdata = imem[addr];
endmodule

module mips_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic        stall,
    input  logic [31:0] target,
    output logic [31:0] pc
);
    logic [31:0] PC;

    always_ff @(posedge clk) begin
        if (!rst)          PC <= RESET_PC;
        else if (redirect) PC <= target;
        else if (!stall)   PC <= PC + 32'd4;
    end

    assign pc = PC;
endmodule

module mips_rf (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] rf [0:31];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we && wa != 5'd0) begin
            rf[wa] <= wd;
        end
    end

    // Write-through so ID sees the value WB is committing this cycle.
    always_comb begin
        rd1 = rf[ra1];
        rd2 = rf[ra2];
        if (ra1 == 5'd0)                rd1 = '0;
        else if (we && wa == ra1)       rd1 = wd;
        if (ra2 == 5'd0)                rd2 = '0;
        else if (we && wa == ra2)       rd2 = wd;
    end
endmodule

module mips_dmem #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        we,
    input  logic [9:0]  addr,
    input  logic [31:0] wd,
    output logic [31:0] rd
);
    logic [31:0] dmem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) dmem[addr] <= wd;
    end

    assign rd = dmem[addr];
endmodule

module mips_pipeline #(
    parameter int          IM_DEPTH = 1024,
    parameter int          DM_DEPTH = 1024,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_LUI} alu_op_t;
    typedef struct packed {
        logic    regwrite;
        logic    memread;
        logic    memwrite;
        logic    branch;
        logic    jump;
        logic    alusrc;
        alu_op_t alu_op;
    } ctrl_t;

    logic [31:0] pc, instr, target;
    logic        stall, redirect;

    logic [31:0] ifid_instr, ifid_pc4;

    ctrl_t       idex_ctrl;
    logic [31:0] idex_pc4, idex_a, idex_b, idex_imm;
    logic [4:0]  idex_rs, idex_rt, idex_dst;
    logic [25:0] idex_jaddr;

    logic        exmem_regwrite, exmem_memread, exmem_memwrite;
    logic [31:0] exmem_alu, exmem_store;
    logic [4:0]  exmem_dst;

    logic        memwb_regwrite;
    logic [31:0] memwb_val;
    logic [4:0]  memwb_dst;

    logic [31:0] rd1, rd2, dm_rd, mem_val;

    mips_pc #(.RESET_PC(RESET_PC)) U_PC (
        .clk(clk), .rst(rst), .redirect(redirect), .stall(stall), .target(target), .pc(pc)
    );

    mips_imem #(.DEPTH(IM_DEPTH)) U_IM (
        .clk(clk), .we(1'b0), .waddr(10'd0), .wdata(32'd0), .addr(pc[11:2]), .rdata(instr)
    );

    // ID: decode
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, dst;
    logic [31:0] imm_ext;
    ctrl_t       ctrl;
    logic        uses_rs, uses_rt;

    assign op    = ifid_instr[31:26];
    assign rs    = ifid_instr[25:21];
    assign rt    = ifid_instr[20:16];
    assign rd    = ifid_instr[15:11];
    assign funct = ifid_instr[5:0];

    always_comb begin
        ctrl    = '0;
        dst     = rt;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        imm_ext = {{16{ifid_instr[15]}}, ifid_instr[15:0]};
        case (op)
            6'h00: begin
                dst = rd;
                ctrl.regwrite = 1'b1;
                uses_rs = 1'b1;
                uses_rt = 1'b1;
                case (funct)
                    6'h21:   ctrl.alu_op = ALU_ADD;
                    6'h23:   ctrl.alu_op = ALU_SUB;
                    6'h24:   ctrl.alu_op = ALU_AND;
                    6'h25:   ctrl.alu_op = ALU_OR;
                    6'h2A:   ctrl.alu_op = ALU_SLT;
                    default: begin
                        ctrl.regwrite = 1'b0;
                        uses_rs = 1'b0;
                        uses_rt = 1'b0;
                    end
                endcase
            end
            6'h09: begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; uses_rs = 1'b1; end
            6'h0D: begin
                ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.alu_op = ALU_OR; uses_rs = 1'b1;
                imm_ext = {16'h0000, ifid_instr[15:0]};
            end
            6'h0F: begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.alu_op = ALU_LUI; end
            6'h23: begin ctrl.regwrite = 1'b1; ctrl.memread = 1'b1; ctrl.alusrc = 1'b1; uses_rs = 1'b1; end
            6'h2B: begin ctrl.memwrite = 1'b1; ctrl.alusrc = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
            6'h04: begin ctrl.branch = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
            6'h02: ctrl.jump = 1'b1;
            default: ;
        endcase
    end

    mips_rf U_RF (
        .clk(clk), .rst(rst), .we(memwb_regwrite), .wa(memwb_dst), .wd(memwb_val),
        .ra1(rs), .ra2(rt), .rd1(rd1), .rd2(rd2)
    );

    assign stall = idex_ctrl.memread &&
                   ((uses_rs && idex_dst == rs) || (uses_rt && idex_dst == rt));

    // EX: operand forwarding, EX/MEM result wins over MEM/WB
    logic [31:0] fwd_a, fwd_b, alu_b, alu_y;

    always_comb begin
        fwd_a = idex_a;
        fwd_b = idex_b;
        if (exmem_regwrite && exmem_dst != 5'd0 && exmem_dst == idex_rs)      fwd_a = exmem_alu;
        else if (memwb_regwrite && memwb_dst != 5'd0 && memwb_dst == idex_rs) fwd_a = memwb_val;
        if (exmem_regwrite && exmem_dst != 5'd0 && exmem_dst == idex_rt)      fwd_b = exmem_alu;
        else if (memwb_regwrite && memwb_dst != 5'd0 && memwb_dst == idex_rt) fwd_b = memwb_val;
    end

    assign alu_b = idex_ctrl.alusrc ? idex_imm : fwd_b;

    always_comb begin
        case (idex_ctrl.alu_op)
            ALU_SUB: alu_y = fwd_a - alu_b;
            ALU_AND: alu_y = fwd_a & alu_b;
            ALU_OR:  alu_y = fwd_a | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(fwd_a) < $signed(alu_b)};
            ALU_LUI: alu_y = {alu_b[15:0], 16'h0000};
            default: alu_y = fwd_a + alu_b;
        endcase
    end

    assign redirect = (idex_ctrl.branch && fwd_a == fwd_b) || idex_ctrl.jump;
    assign target   = idex_ctrl.jump ? {idex_pc4[31:28], idex_jaddr, 2'b00}
                                     : idex_pc4 + {idex_imm[29:0], 2'b00};

    mips_dmem #(.DEPTH(DM_DEPTH)) U_DM (
        .clk(clk), .we(exmem_memwrite), .addr(exmem_alu[11:2]), .wd(exmem_store), .rd(dm_rd)
    );

    assign mem_val = exmem_memread ? dm_rd : exmem_alu;

    // A taken redirect squashes IF/ID and ID/EX even if a load-use stall is pending.
    always_ff @(posedge clk) begin
        if (!rst || redirect) begin
            ifid_instr <= '0;
            ifid_pc4   <= '0;
        end else if (!stall) begin
            ifid_instr <= instr;
            ifid_pc4   <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || redirect || stall) begin
            idex_ctrl  <= '0;
            idex_pc4   <= '0;
            idex_a     <= '0;
            idex_b     <= '0;
            idex_imm   <= '0;
            idex_rs    <= '0;
            idex_rt    <= '0;
            idex_dst   <= '0;
            idex_jaddr <= '0;
        end else begin
            idex_ctrl  <= ctrl;
            idex_pc4   <= ifid_pc4;
            idex_a     <= rd1;
            idex_b     <= rd2;
            idex_imm   <= imm_ext;
            idex_rs    <= rs;
            idex_rt    <= rt;
            idex_dst   <= dst;
            idex_jaddr <= ifid_instr[25:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            exmem_regwrite <= 1'b0;
            exmem_memread  <= 1'b0;
            exmem_memwrite <= 1'b0;
            exmem_alu      <= '0;
            exmem_store    <= '0;
            exmem_dst      <= '0;
            memwb_regwrite <= 1'b0;
            memwb_val      <= '0;
            memwb_dst      <= '0;
        end else begin
            exmem_regwrite <= idex_ctrl.regwrite;
            exmem_memread  <= idex_ctrl.memread;
            exmem_memwrite <= idex_ctrl.memwrite;
            exmem_alu      <= alu_y;
            exmem_store    <= fwd_b;
            exmem_dst      <= idex_dst;
            memwb_regwrite <= exmem_regwrite;
            memwb_val      <= mem_val;
            memwb_dst      <= exmem_dst;
        end
    end
endmodule

// File: tb/tb_mips_pipeline.sv
// Bench for mips_pipeline: an instruction-at-a-time ISA interpreter supplies the ordered sequence of
// architectural states; every cycle the core's rf/dmem must sit on that sequence, never moving backwards.

module tb_mips_pipeline;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mips_pipeline dut (.clk(clk), .rst(rst));

    localparam int MAXS = 128;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prog [0:63];
    logic [31:0] m_rf [0:31];
    logic [31:0] m_dm [0:15];
    logic [31:0] snap_rf [0:MAXS-1][0:31];
    logic [31:0] snap_dm [0:MAXS-1][0:15];
    int          nsnap = 0;
    int          sp = 0;
    bit          mon_on = 1'b0;

    function automatic logic [31:0] enc_r(input logic [5:0] funct, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic bit state_eq(input int j);
        for (int r = 0; r < 32; r++) if (dut.U_RF.rf[r] !== snap_rf[j][r]) return 1'b0;
        for (int a = 0; a < 16; a++) if (dut.U_DM.dmem[a] !== snap_dm[j][a]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic take_snap();
        for (int r = 0; r < 32; r++) snap_rf[nsnap][r] = m_rf[r];
        for (int a = 0; a < 16; a++) snap_dm[nsnap][a] = m_dm[a];
        nsnap++;
    endtask

    function automatic void wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_rf[r] = v;
    endfunction

    // Plain sequential ISA semantics: one instruction at a time, no pipeline notion.
    task automatic run_model(input int len);
        logic [31:0] pc, w, a, b, sx, ea;
        int steps;
        for (int r = 0; r < 32; r++) m_rf[r] = 32'h0;
        nsnap = 0;
        take_snap();
        pc = 32'h0;
        steps = 0;
        while (pc < 32'(len * 4) && steps < MAXS - 1) begin
            w  = prog[pc[7:2]];
            a  = m_rf[w[25:21]];
            b  = m_rf[w[20:16]];
            sx = {{16{w[15]}}, w[15:0]};
            ea = a + sx;
            pc = pc + 32'd4;
            case (w[31:26])
                6'h00: case (w[5:0])
                    6'h21: wr(w[15:11], a + b);
                    6'h23: wr(w[15:11], a - b);
                    6'h24: wr(w[15:11], a & b);
                    6'h25: wr(w[15:11], a | b);
                    6'h2A: wr(w[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                    default: ;
                endcase
                6'h09: wr(w[20:16], a + sx);
                6'h0D: wr(w[20:16], a | {16'h0, w[15:0]});
                6'h0F: wr(w[20:16], {w[15:0], 16'h0});
                6'h23: wr(w[20:16], m_dm[ea[5:2]]);
                6'h2B: m_dm[ea[5:2]] = b;
                6'h04: if (a == b) pc = pc + (sx << 2);
                6'h02: pc = {pc[31:28], w[25:0], 2'b00};
                default: ;
            endcase
            steps++;
            take_snap();
        end
    endtask

    always @(negedge clk) begin
        int j;
        if (!mon_on) begin
            sp = 0;
        end else begin
            j = sp;
            while (j < nsnap && !state_eq(j)) j++;
            checks++;
            if (j < nsnap) begin
                sp = j;
            end else begin
                errors++;
                $display("FAIL arch_state @%0t: rf/dmem match no ISA state at or after step %0d (rf1=%h rf2=%h dm0=%h)",
                         $time, sp, dut.U_RF.rf[1], dut.U_RF.rf[2], dut.U_DM.dmem[0]);
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    endtask

    task automatic run_prog(input string name, input int len, input int ncyc, input bit final_chk,
                            output int holds);
        logic [31:0] prev;
        bit rf_zero;
        mon_on = 1'b0;
        for (int i = 0; i < 1024; i++) dut.U_IM.imem[i] <= (i < len) ? prog[i] : 32'h0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({name, " reset PC"}, dut.U_PC.PC, 32'h0);
        check({name, " reset instr"}, dut.instr, prog[0]);
        rf_zero = 1'b1;
        for (int r = 0; r < 32; r++) if (dut.U_RF.rf[r] !== 32'h0) rf_zero = 1'b0;
        check({name, " reset rf cleared"}, {31'd0, rf_zero}, 32'd1);
        run_model(len);
        rst = 1'b1;
        mon_on = 1'b1;
        @(posedge clk);
        #1;
        check({name, " PC after first cycle"}, dut.U_PC.PC, 32'h4);
        prev = 32'h4;
        holds = 0;
        repeat (ncyc) begin
            @(posedge clk);
            #1;
            if (dut.U_PC.PC == prev) holds++;
            prev = dut.U_PC.PC;
        end
        mon_on = 1'b0;
        if (final_chk) begin
            checks++;
            if (!state_eq(nsnap - 1)) begin
                errors++;
                $display("FAIL %s final state: rf/dmem differ from ISA result (rf1=%h expected %h)",
                         name, dut.U_RF.rf[1], snap_rf[nsnap-1][1]);
            end
        end
    endtask

    task automatic gen_random(input int len, input bit allow_store);
        clear_prog();
        for (int i = 0; i < len; i++) begin
            logic [4:0] rs, rt, rd;
            int k;
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(0, 7));
            k  = int'($urandom_range(0, 11));
            case (k)
                0: prog[i] = enc_r(6'h21, rs, rt, rd);
                1: prog[i] = enc_r(6'h23, rs, rt, rd);
                2: prog[i] = enc_r(6'h24, rs, rt, rd);
                3: prog[i] = enc_r(6'h25, rs, rt, rd);
                4: prog[i] = enc_r(6'h2A, rs, rt, rd);
                5: prog[i] = enc_i(6'h09, rs, rt, 16'($urandom));
                6: prog[i] = enc_i(6'h0D, rs, rt, 16'($urandom));
                7: prog[i] = enc_i(6'h0F, 5'd0, rt, 16'($urandom));
                8: prog[i] = enc_i(6'h23, 5'd0, rt, 16'($urandom_range(0, 15) * 4));
                9: prog[i] = allow_store ? enc_i(6'h2B, 5'd0, rt, 16'($urandom_range(0, 15) * 4))
                                         : enc_i(6'h09, rs, rt, 16'($urandom));
                10: prog[i] = enc_i(6'h04, rs, rt, 16'($urandom_range(0, 3)));
                default: begin
                    if ($urandom_range(0, 1) == 0)      prog[i] = {6'h02, 26'($urandom_range(i + 1, len))};
                    else if ($urandom_range(0, 1) == 0) prog[i] = enc_r(6'h3F, rs, rt, rd);
                    else                                prog[i] = {6'h3F, 26'($urandom)};
                end
            endcase
        end
    endtask

    initial begin
        int holds;
        for (int i = 0; i < 1024; i++) dut.U_DM.dmem[i] <= 32'h0;
        for (int a = 0; a < 16; a++) m_dm[a] = 32'h0;

        clear_prog();
        prog[0] = enc_i(6'h0D, 5'd0, 5'd1, 16'd5);
        prog[1] = enc_i(6'h09, 5'd1, 5'd2, 16'd3);
        prog[2] = enc_r(6'h23, 5'd2, 5'd1, 5'd3);
        prog[3] = enc_r(6'h2A, 5'd3, 5'd2, 5'd4);
        prog[4] = enc_i(6'h0F, 5'd0, 5'd5, 16'h1234);
        run_prog("alu", 5, 30, 1'b1, holds);
        check("alu rf[2]", dut.U_RF.rf[2], 32'd8);
        check("alu rf[3]", dut.U_RF.rf[3], 32'd3);
        check("alu rf[4]", dut.U_RF.rf[4], 32'd1);
        check("alu rf[5]", dut.U_RF.rf[5], 32'h1234_0000);

        clear_prog();
        prog[0] = enc_i(6'h0D, 5'd0, 5'd1, 16'h002A);
        prog[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
        prog[2] = enc_i(6'h23, 5'd0, 5'd2, 16'd8);
        prog[3] = enc_r(6'h21, 5'd2, 5'd2, 5'd3);
        run_prog("ldst", 4, 30, 1'b1, holds);
        check("ldst dmem[2]", dut.U_DM.dmem[2], 32'h2A);
        check("ldst rf[3]", dut.U_RF.rf[3], 32'h54);
        check("ldst PC hold cycles", 32'(holds), 32'd1);

        clear_prog();
        prog[0] = enc_i(6'h0D, 5'd0, 5'd1, 16'd1);
        prog[1] = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
        prog[2] = enc_i(6'h0D, 5'd0, 5'd2, 16'd7);
        prog[3] = enc_i(6'h0D, 5'd0, 5'd3, 16'd9);
        prog[4] = enc_i(6'h0D, 5'd0, 5'd4, 16'd4);
        run_prog("beq_taken", 5, 30, 1'b1, holds);
        check("beq_taken rf[2]", dut.U_RF.rf[2], 32'd0);
        check("beq_taken rf[3]", dut.U_RF.rf[3], 32'd0);
        check("beq_taken rf[4]", dut.U_RF.rf[4], 32'd4);

        prog[1] = enc_i(6'h04, 5'd1, 5'd0, 16'd2);
        run_prog("beq_not_taken", 5, 30, 1'b1, holds);
        check("beq_not_taken rf[2]", dut.U_RF.rf[2], 32'd7);
        check("beq_not_taken rf[3]", dut.U_RF.rf[3], 32'd9);
        check("beq_not_taken rf[4]", dut.U_RF.rf[4], 32'd4);

        clear_prog();
        prog[0]  = {6'h02, 26'h10};
        prog[1]  = enc_i(6'h0D, 5'd0, 5'd5, 16'd1);
        prog[16] = enc_i(6'h0D, 5'd0, 5'd6, 16'd2);
        run_prog("jump", 17, 30, 1'b1, holds);
        check("jump rf[5]", dut.U_RF.rf[5], 32'd0);
        check("jump rf[6]", dut.U_RF.rf[6], 32'd2);

        clear_prog();
        prog[0] = enc_i(6'h09, 5'd0, 5'd0, 16'd7);
        prog[1] = 32'hFC07_1234;
        prog[2] = enc_r(6'h3F, 5'd0, 5'd0, 5'd8);
        prog[3] = enc_i(6'h0D, 5'd0, 5'd1, 16'd3);
        run_prog("zero_undef", 4, 30, 1'b1, holds);
        check("zero_undef rf[0]", dut.U_RF.rf[0], 32'd0);
        check("zero_undef rf[7]", dut.U_RF.rf[7], 32'd0);
        check("zero_undef rf[8]", dut.U_RF.rf[8], 32'd0);
        check("zero_undef rf[1]", dut.U_RF.rf[1], 32'd3);

        for (int n = 0; n < 6; n++) begin
            gen_random(40, 1'b1);
            run_prog("random", 40, 140, 1'b1, holds);
        end

        // Cut a store-free program short so the next reset lands on a busy pipeline.
        gen_random(40, 1'b0);
        run_prog("random_cut", 40, 9, 1'b0, holds);
        gen_random(40, 1'b1);
        run_prog("random_after_cut", 40, 140, 1'b1, holds);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
